// File: rtl/alu_multiciclo_if.sv
// ---------------------------------------------------------------------------
// alu_multiciclo_if
// Operation/result bundle between the control FSM (master) and the
// execution-stage ALU (slave).
//
// Handshake: the master raises START with ALUSELECT/A/B valid. The ALU
// samples START only while idle (BUSY=0). An iterative shift raises BUSY
// until it completes. DONE is a one-cycle pulse, and RESULT/SALTO are valid
// during that pulse. RESULT/SALTO then hold until the next DONE. A START
// raised during the DONE cycle is accepted, so operations can be issued
// back-to-back.
//
// Signals:
//   START      master->slave  operation request
//   ALUSELECT  master->slave  4-bit operation code
//   A, B       master->slave  operands (shift amount = B[SHAMT_W-1:0])
//   RESULT     slave->master  registered result
//   SALTO      slave->master  registered branch condition
//   BUSY       slave->master  iterative shift in progress
//   DONE       slave->master  completion pulse
//   STATE_DBG  slave->master  FSM state (0 = IDLE, 1 = SHIFT), for debug
// ---------------------------------------------------------------------------
interface alu_multiciclo_if #(
  parameter int WIDTH = 32
);
  logic             START;
  logic [3:0]       ALUSELECT;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] RESULT;
  logic             SALTO;
  logic             BUSY;
  logic             DONE;
  logic             STATE_DBG;

  modport master (
    output START, ALUSELECT, A, B,
    input  RESULT, SALTO, BUSY, DONE, STATE_DBG
  );

  modport slave (
    input  START, ALUSELECT, A, B,
    output RESULT, SALTO, BUSY, DONE, STATE_DBG
  );
endinterface

// File: rtl/alu_multiciclo.sv
// ---------------------------------------------------------------------------
// alu_multiciclo
// Execution-stage ALU for the multicycle RISC-V core. Single-cycle ops
// (ADD/AND/OR/SLT/SUB/XOR/branches/unknown) load RESULT/SALTO on the START
// edge. SLL/SRL run on an iterative 1-bit-per-cycle shifter.
//
// Ports:
//   CLK      system clock (rising edge)
//   RESET_N  asynchronous active-low reset
//   bus      alu_multiciclo_if.slave (START, ALUSELECT, A, B ->
//            RESULT, SALTO, BUSY, DONE, STATE_DBG)
//
// Build option: define ALU_SRA_EN to make code 1100 an iterative arithmetic
// right shift. When it is undefined, 1100 is an unknown code.
// ---------------------------------------------------------------------------
module alu_multiciclo #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic            CLK,
  input  logic            RESET_N,
  alu_multiciclo_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SLT = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_BNE = 4'b1001;
  localparam logic [3:0] OP_BLT = 4'b1010;
  localparam logic [3:0] OP_BGE = 4'b1011;
`ifdef ALU_SRA_EN
  localparam logic [3:0] OP_SRA = 4'b1100;
`endif

  localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;
  localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  typedef enum logic [1:0] {SK_SLL = 2'd0, SK_SRL = 2'd1, SK_SRA = 2'd2} shift_kind_t;

  state_t           state_q, state_d;
  shift_kind_t      kind_q, kind_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             salto_q, salto_d;
  logic             done_q, done_d;

  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  shift_kind_t        kind_new;
  logic [WIDTH-1:0]   one_res;
  logic               one_salto;
  logic [WIDTH-1:0]   sh_next;

  assign shamt = bus.B[SHAMT_W-1:0];

  // Decode the operation and compute the result that completes in one cycle.
  // A shift by zero also finishes here, with RESULT = A.
  always_comb begin
    is_shift  = 1'b0;
    kind_new  = SK_SLL;
    one_res   = '0;
    one_salto = 1'b0;
    case (bus.ALUSELECT)
      OP_ADD: one_res = bus.A + bus.B;
      OP_AND: one_res = bus.A & bus.B;
      OP_OR:  one_res = bus.A | bus.B;
      OP_SUB: one_res = bus.A - bus.B;
      OP_XOR: one_res = bus.A ^ bus.B;
      OP_SLT: one_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_SLL: begin
        is_shift = 1'b1;
        kind_new = SK_SLL;
        one_res  = bus.A;
      end
      OP_SRL: begin
        is_shift = 1'b1;
        kind_new = SK_SRL;
        one_res  = bus.A;
      end
`ifdef ALU_SRA_EN
      OP_SRA: begin
        is_shift = 1'b1;
        kind_new = SK_SRA;
        one_res  = bus.A;
      end
`endif
      OP_BEQ: one_salto = (bus.A == bus.B);
      OP_BNE: one_salto = (bus.A != bus.B);
      OP_BLT: one_salto = ($signed(bus.A) <  $signed(bus.B));
      OP_BGE: one_salto = ($signed(bus.A) >= $signed(bus.B));
      default: begin
        one_res   = '0;
        one_salto = 1'b0;
      end
    endcase
  end

  // One step of the shifter. SRA refills from the current MSB, which is
  // still the sign bit of the original A.
  always_comb begin
    case (kind_q)
      SK_SLL:  sh_next = {sh_q[WIDTH-2:0], 1'b0};
      SK_SRL:  sh_next = {1'b0, sh_q[WIDTH-1:1]};
      SK_SRA:  sh_next = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
      default: sh_next = sh_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    salto_d  = salto_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          if (is_shift && (shamt != CNT_ZERO)) begin
            sh_d    = bus.A;
            cnt_d   = shamt;
            kind_d  = kind_new;
            state_d = SHIFT;
          end else begin
            result_d = one_res;
            salto_d  = one_salto;
            done_d   = 1'b1;
          end
        end
      end
      SHIFT: begin
        // Operands and START are ignored here. The result is taken from the
        // edge where the counter drops to zero.
        sh_d  = sh_next;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d = sh_next;
          salto_d  = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      kind_q   <= SK_SLL;
      sh_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      salto_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      salto_q  <= salto_d;
      done_q   <= done_d;
    end
  end

  assign bus.RESULT    = result_q;
  assign bus.SALTO     = salto_q;
  assign bus.BUSY      = (state_q == SHIFT);
  assign bus.DONE      = done_q;
  assign bus.STATE_DBG = state_q;

endmodule

// File: doc/alu_multiciclo.md
Name: alu_multiciclo

Overview:
- Execution-stage ALU for the multicycle RISC-V core.
- Sits directly downstream of the ALU control decoder and consumes its 4-bit ALUSELECT code plus the two operands. Produces RESULT and a branch-condition flag.
- Single-cycle ops complete in one cycle. Shifts run on an iterative 1-bit/cycle shifter, with a START/BUSY/DONE handshake to the control FSM.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, $clog2(WIDTH), shift-amount width; the shift amount is taken from B[SHAMT_W-1:0].

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- START  input  1  operation request; sampled only in IDLE.
- ALUSELECT  input  4  operation code from the ALU control decoder.
- A  input  WIDTH  operand 1 (rs1).
- B  input  WIDTH  operand 2 (rs2 or immediate).
- RESULT  output  WIDTH  registered result; held until the next DONE.
- SALTO  output  1  registered branch condition; held until the next DONE.
- BUSY  output  1  high while an iterative shift is in progress.
- DONE  output  1  single-cycle pulse; RESULT and SALTO are valid in the same cycle.

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - state=IDLE.
  - RESULT=0, SALTO=0, BUSY=0, DONE=0.
  - Internal shift register and counter cleared.
  - Applies at any time, including mid-shift; an aborted op produces no DONE.
- States: IDLE, SHIFT.
- Operation codes:
  - 0000 ADD
  - 0001 AND
  - 0010 OR
  - 0011 SLL
  - 0100 SLT (signed)
  - 0101 SRL
  - 0110 SUB
  - 0111 XOR
  - 1000 BEQ
  - 1001 BNE
  - 1010 BLT (signed)
  - 1011 BGE (signed)
  - 1100-1111 unknown
- Arithmetic rules: two's-complement, WIDTH bits, wrap-around, no carry/overflow output.
- SLT result is {0...,1} or 0.
- Non-shift op, IDLE with START=1 at edge k:
  - RESULT loaded at edge k; DONE=1 for the cycle after edge k; BUSY stays 0.
- Branch codes:
  - RESULT=0.
  - SALTO = condition (A==B, A!=B, A<B, A>=B).
  - SALTO=0 for all non-branch codes.
- Unknown codes: RESULT=0, SALTO=0, latency 1 (same as non-shift).
- Shift op (SLL/SRL), IDLE with START=1 at edge k, n=B[SHAMT_W-1:0]:
  - n=0: behaves as non-shift; RESULT=A at edge k.
  - n>0, edge k: A loaded into the shift register, counter=n, state=SHIFT, BUSY=1.
  - n>0, SHIFT state: each edge shifts by 1 (SRL zero-fills) and decrements the counter.
  - n>0, completion: at the edge where the counter reaches 0, RESULT is loaded, BUSY=0, state=IDLE, DONE=1 for the following cycle.
  - Total: DONE in the cycle after edge k+n; BUSY high for n cycles.
- START while BUSY=1 is ignored; ALUSELECT/A/B changes during SHIFT have no effect.
- START in the DONE cycle (state already IDLE) is accepted, giving back-to-back ops.
- DONE is never high for two consecutive cycles from one START.
- B bits above SHAMT_W are ignored for shifts; B=32 with WIDTH=32 is a shift by 0.

Optional Feature:
- Macro: ALU_SRA_EN.
- Defined:
  - Code 1100 = SRA.
  - Iterative like SRL but sign-fills from A[WIDTH-1]; same latency n+1.
- Undefined:
  - 1100 is treated as unknown: RESULT=0, SALTO=0, latency 1, no SHIFT entry.

Test Plan:
- ADD A=5, B=7, START 1 cycle -> RESULT=12 and DONE=1 in the next cycle; BUSY never asserted; SALTO=0.
- SUB A=3, B=5 -> RESULT=0xFFFFFFFE. Then SLT A=0xFFFFFFFF, B=1 -> RESULT=1, issued back-to-back in the DONE cycle.
- SLL A=1, B=4 -> BUSY=1 for 4 cycles, DONE in the cycle after edge k+4, RESULT=0x00000010. A second START pulse mid-shift is ignored (exactly one DONE).
- SRL A=0x80000000, B=31 -> DONE after 31 shift cycles, RESULT=0x00000001. SRL with B=32 -> latency 1, RESULT=0x80000000.
- Branches:
  - BLT A=0xFFFFFFFE, B=1 -> SALTO=1, RESULT=0.
  - BGE same operands -> SALTO=0.
  - BEQ A=B=5 -> SALTO=1.
  - BNE A=B=5 -> SALTO=0.
- SLL A=1, B=10, RESET_N low after 2 shift cycles -> RESULT=0, BUSY=0, DONE=0, no DONE ever produced. Next ADD 1+1 -> RESULT=2 with latency 1. With ALU_SRA_EN: code 1100, A=0x80000000, B=4 -> 0xF8000000 after 4 shift cycles.
